// File: rtl/mips_isa_pkg.sv
// rtl/mips_isa_pkg.sv - MIPS format tags, opcodes, encoder FSM states and the word packer
package mips_isa_pkg;

  typedef enum logic [1:0] {
    FMT_R    = 2'b00,
    FMT_I    = 2'b01,
    FMT_J    = 2'b10,
    FMT_RSVD = 2'b11
  } fmt_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Returns {legal, word}; an illegal bundle yields legal=0 and the word is ignored.
  function automatic logic [32:0] encode_word(
    input logic [1:0]  fmt,
    input logic [5:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [5:0]  funct,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic        legal;
    logic [31:0] word;
    legal = 1'b0;
    word  = '0;
    case (fmt)
      FMT_R: begin
        legal = (op == OP_RTYPE);
        word  = {6'b0, rs, rt, rd, shamt, funct};
      end
      FMT_I: begin
        legal = (op != OP_RTYPE) && (op != OP_J) && (op != OP_JAL);
        word  = {op, rs, rt, imm};
      end
      FMT_J: begin
        legal = (op == OP_J) || (op == OP_JAL);
        word  = {op, target};
      end
      default: ;
    endcase
    return {legal, word};
  endfunction

endpackage

// File: rtl/encoder_fifo.sv
// rtl/encoder_fifo.sv - synchronous FIFO buffering encoded words ahead of the IMEM writer
module encoder_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rest,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  // Full comes from the registered count: a same-cycle pop never frees room for a push.
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs MIPS field bundles into words and streams them into IMEM
module instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              start,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [5:0]        op,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic              ovf,
  output logic              done
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  state_t            state;
  state_t            state_nxt;
  logic              enc_valid;
  logic [31:0]       enc_word;
  logic [32:0]       enc_res;
  logic [ADDR_W-1:0] ptr;
  logic              accept;
  logic              fifo_push;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_clr;
  logic [31:0]       fifo_head;
  logic              wr_fire;
  logic              wr_last;

  assign enc_res   = encode_word(fmt, op, rs, rt, rd, shamt, funct, imm, target);
  assign in_ready  = (state == ST_LOAD) && (!enc_valid || !fifo_full);
  assign accept    = in_valid && in_ready;
  assign fifo_push = enc_valid && !fifo_full;
  assign mem_we    = !fifo_empty && ((state == ST_LOAD) || (state == ST_DRAIN)) && !ovf;
  assign wr_fire   = mem_we && mem_ready;
  assign wr_last   = wr_fire && (ptr == LAST);
  assign fifo_clr  = start || wr_last;
  assign mem_addr  = ptr;
  assign mem_wdata = mem_we ? fifo_head : 32'h0;
  assign done      = (state == ST_DONE);

  encoder_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk   (clk),
    .rest  (rest),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .pop   (wr_fire),
    .wdata (enc_word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_ff @(posedge clk or posedge rest) begin
    if (rest) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ST_LOAD;
    end else if (wr_last) begin
      state_nxt = ST_DONE;
    end else begin
      case (state)
        ST_LOAD:  if (flush) state_nxt = ST_DRAIN;
        ST_DRAIN: if (!enc_valid && fifo_empty) state_nxt = ST_DONE;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      enc_valid <= 1'b0;
      enc_word  <= '0;
      ptr       <= BASE;
      count     <= '0;
      err       <= 1'b0;
      ovf       <= 1'b0;
    end else if (start) begin
      enc_valid <= 1'b0;
      ptr       <= BASE;
      count     <= '0;
      err       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (wr_last)        enc_valid <= 1'b0;
      else if (accept)    enc_valid <= enc_res[32];
      else if (fifo_push) enc_valid <= 1'b0;
      if (accept) enc_word <= enc_res[31:0];
      if (accept && !enc_res[32]) err <= 1'b1;
      // The last address is final: the pointer parks there instead of wrapping.
      if (wr_fire) begin
        count <= count + (ADDR_W+1)'(1);
        if (!wr_last) ptr <= ptr + ADDR_W'(1);
      end
      if (wr_last) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed vector bench for instr_encoder
module tb_instr_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rest, start, flush, in_valid_a, in_valid_b, mem_ready;
  logic [1:0]  fmt;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;

  logic        a_in_ready, a_mem_we, a_err, a_ovf, a_done;
  logic [9:0]  a_mem_addr;
  logic [31:0] a_mem_wdata;
  logic [10:0] a_count;

  logic        b_in_ready, b_mem_we, b_err, b_ovf, b_done;
  logic [1:0]  b_mem_addr;
  logic [31:0] b_mem_wdata;
  logic [2:0]  b_count;

  instr_encoder #(.ADDR_W(10), .BASE_ADDR(0), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rest(rest), .start(start), .flush(flush),
    .in_valid(in_valid_a), .in_ready(a_in_ready),
    .fmt(fmt), .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm(imm), .target(target),
    .mem_we(a_mem_we), .mem_ready(mem_ready), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .count(a_count), .err(a_err), .ovf(a_ovf), .done(a_done)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rest(rest), .start(start), .flush(flush),
    .in_valid(in_valid_b), .in_ready(b_in_ready),
    .fmt(fmt), .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm(imm), .target(target),
    .mem_we(b_mem_we), .mem_ready(mem_ready), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .count(b_count), .err(b_err), .ovf(b_ovf), .done(b_done)
  );

  typedef struct packed {
    logic [1:0]  fmt;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
  } bundle_t;

  typedef struct packed {
    bundle_t     b;
    logic        legal;
    logic [31:0] word;
  } vec_t;

  vec_t        vecs [15];
  int          qa_addr[$], qb_addr[$];
  logic [31:0] qa_data[$], qb_data[$];
  int          n_checks = 0;
  int          n_fail = 0;

  always begin
    @(negedge clk);
    #2;
    if (a_mem_we && mem_ready) begin
      qa_addr.push_back(int'(a_mem_addr));
      qa_data.push_back(a_mem_wdata);
    end
    if (b_mem_we && mem_ready) begin
      qb_addr.push_back(int'(b_mem_addr));
      qb_data.push_back(b_mem_wdata);
    end
  end

  function automatic bundle_t mk(input logic [1:0] f, input logic [5:0] o, input logic [4:0] s,
                                 input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                                 input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg);
    bundle_t r;
    r.fmt = f; r.op = o; r.rs = s; r.rt = t; r.rd = d; r.shamt = sh;
    r.funct = fn; r.imm = im; r.target = tg;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input bundle_t b, input bit to_b);
    bit acc;
    acc = 1'b0;
    fmt = b.fmt; op = b.op; rs = b.rs; rt = b.rt; rd = b.rd;
    shamt = b.shamt; funct = b.funct; imm = b.imm; target = b.target;
    if (to_b) in_valid_b = 1'b1;
    else      in_valid_a = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      acc = to_b ? b_in_ready : a_in_ready;
      @(negedge clk);
    end
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    chk("send_accepted", 64'(acc), 64'd1);
  endtask

  task automatic pulse_start();
    qa_addr.delete(); qa_data.delete(); qb_addr.delete(); qb_data.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_done_a();
    int n;
    n = 0;
    while (!a_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("a_done_reached", 64'(a_done), 64'd1);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_in_ready"}, 64'(a_in_ready), 64'd0);
    chk({tag, "_mem_we"}, 64'(a_mem_we), 64'd0);
    chk({tag, "_mem_addr"}, 64'(a_mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(a_mem_wdata), 64'd0);
    chk({tag, "_count"}, 64'(a_count), 64'd0);
    chk({tag, "_err"}, 64'(a_err), 64'd0);
    chk({tag, "_ovf"}, 64'(a_ovf), 64'd0);
    chk({tag, "_done"}, 64'(a_done), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{mk(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'h0, 26'h0), 1'b1, 32'h00221821};
    vecs[1]  = '{mk(2'd0, 6'h00, 5'd0, 5'd5, 5'd4, 5'd3, 6'h00, 16'h0, 26'h0), 1'b1, 32'h000520C0};
    vecs[2]  = '{mk(2'd0, 6'h00, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'h1234, 26'h2AAAAAA), 1'b1, 32'h03FFFFFF};
    vecs[3]  = '{mk(2'd1, 6'h23, 5'd29, 5'd8, 5'd0, 5'd0, 6'h00, 16'hFFFC, 26'h0), 1'b1, 32'h8FA8FFFC};
    vecs[4]  = '{mk(2'd1, 6'h0D, 5'd0, 5'd1, 5'd7, 5'd9, 6'h3F, 16'hABCD, 26'h155), 1'b1, 32'h3401ABCD};
    vecs[5]  = '{mk(2'd1, 6'h01, 5'd4, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0010, 26'h0), 1'b1, 32'h04800010};
    vecs[6]  = '{mk(2'd2, 6'h02, 5'd3, 5'd4, 5'd5, 5'd6, 6'h07, 16'hFFFF, 26'h0100000), 1'b1, 32'h08100000};
    vecs[7]  = '{mk(2'd2, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h3FFFFFF), 1'b1, 32'h0FFFFFFF};
    vecs[8]  = '{mk(2'd3, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'h0, 26'h0), 1'b0, 32'h0};
    vecs[9]  = '{mk(2'd0, 6'h08, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'h0, 26'h0), 1'b0, 32'h0};
    vecs[10] = '{mk(2'd1, 6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h5, 26'h0), 1'b0, 32'h0};
    vecs[11] = '{mk(2'd1, 6'h02, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h5, 26'h0), 1'b0, 32'h0};
    vecs[12] = '{mk(2'd1, 6'h03, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h5, 26'h0), 1'b0, 32'h0};
    vecs[13] = '{mk(2'd2, 6'h08, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h100), 1'b0, 32'h0};
    vecs[14] = '{mk(2'd2, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h100), 1'b0, 32'h0};

    rest = 1'b1; start = 1'b0; flush = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0;
    mem_ready = 1'b1;
    fmt = '0; op = '0; rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0; imm = '0; target = '0;
    repeat (2) @(negedge clk);
    chk_reset_a("rst");
    rest = 1'b0;
    @(negedge clk);
    chk_reset_a("idle");
    chk("idle_b_mem_we", 64'(b_mem_we), 64'd0);

    // One bundle per program: encoding and legality table.
    for (int v = 0; v < 15; v++) begin
      pulse_start();
      send(vecs[v].b, 1'b0);
      pulse_flush();
      wait_done_a();
      chk($sformatf("v%0d_count", v), 64'(a_count), 64'(vecs[v].legal));
      chk($sformatf("v%0d_err", v), 64'(a_err), 64'(!vecs[v].legal));
      chk($sformatf("v%0d_nwrites", v), 64'(qa_addr.size()), 64'(vecs[v].legal));
      if (vecs[v].legal && qa_addr.size() > 0) begin
        chk($sformatf("v%0d_addr", v), 64'(qa_addr[0]), 64'd0);
        chk($sformatf("v%0d_data", v), 64'(qa_data[0]), 64'(vecs[v].word));
      end
    end

    // I then J, written in order.
    pulse_start();
    send(mk(2'd1, 6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0005, 26'h0), 1'b0);
    send(vecs[6].b, 1'b0);
    pulse_flush();
    wait_done_a();
    chk("ij_nwrites", 64'(qa_addr.size()), 64'd2);
    if (qa_addr.size() == 2) begin
      chk("ij_addr0", 64'(qa_addr[0]), 64'd0);
      chk("ij_data0", 64'(qa_data[0]), 64'h20220005);
      chk("ij_addr1", 64'(qa_addr[1]), 64'd1);
      chk("ij_data1", 64'(qa_data[1]), 64'h08100000);
    end
    chk("ij_count", 64'(a_count), 64'd2);

    // Backpressure: FIFO plus encode stage fill, then in_ready drops.
    pulse_start();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(vecs[i].b, 1'b0);
    chk("bp_in_ready_low", 64'(a_in_ready), 64'd0);
    chk("bp_mem_we", 64'(a_mem_we), 64'd1);
    fork
      send(vecs[5].b, 1'b0);
      begin
        for (int k = 0; k < 5; k++) begin
          chk($sformatf("bp_hold%0d_ready", k), 64'(a_in_ready), 64'd0);
          chk($sformatf("bp_hold%0d_addr", k), 64'(a_mem_addr), 64'd0);
          chk($sformatf("bp_hold%0d_data", k), 64'(a_mem_wdata), 64'(vecs[0].word));
          @(negedge clk);
        end
        mem_ready = 1'b1;
      end
    join
    pulse_flush();
    wait_done_a();
    chk("bp_nwrites", 64'(qa_addr.size()), 64'd6);
    for (int j = 0; j < 6 && j < qa_addr.size(); j++) begin
      chk($sformatf("bp_addr%0d", j), 64'(qa_addr[j]), 64'(j));
      chk($sformatf("bp_data%0d", j), 64'(qa_data[j]), 64'(vecs[j].word));
    end
    chk("bp_count", 64'(a_count), 64'd6);

    // Illegal bundles leave no gap in the address stream; start clears err.
    pulse_start();
    send(vecs[8].b, 1'b0);
    send(vecs[9].b, 1'b0);
    repeat (2) @(negedge clk);
    chk("ill_err", 64'(a_err), 64'd1);
    chk("ill_no_we", 64'(a_mem_we), 64'd0);
    send(vecs[0].b, 1'b0);
    pulse_flush();
    wait_done_a();
    chk("ill_nwrites", 64'(qa_addr.size()), 64'd1);
    if (qa_addr.size() == 1) begin
      chk("ill_addr", 64'(qa_addr[0]), 64'd0);
      chk("ill_data", 64'(qa_data[0]), 64'h00221821);
    end
    chk("ill_err_sticky", 64'(a_err), 64'd1);
    pulse_start();
    chk("ill_err_cleared", 64'(a_err), 64'd0);
    chk("ill_done_cleared", 64'(a_done), 64'd0);

    // Address space exhaustion on the 2-bit instance.
    pulse_start();
    for (int i = 0; i < 5; i++) send(vecs[i].b, 1'b1);
    for (int n = 0; n < 50 && !b_done; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("ovf_nwrites", 64'(qb_addr.size()), 64'd4);
    for (int j = 0; j < 4 && j < qb_addr.size(); j++) begin
      chk($sformatf("ovf_addr%0d", j), 64'(qb_addr[j]), 64'(j));
      chk($sformatf("ovf_data%0d", j), 64'(qb_data[j]), 64'(vecs[j].word));
    end
    chk("ovf_flag", 64'(b_ovf), 64'd1);
    chk("ovf_done", 64'(b_done), 64'd1);
    chk("ovf_count", 64'(b_count), 64'd4);
    chk("ovf_no_we", 64'(b_mem_we), 64'd0);
    chk("ovf_addr_nowrap", 64'(b_mem_addr), 64'd3);
    chk("ovf_err", 64'(b_err), 64'd0);

    // start in DRAIN discards the buffer; asynchronous reset mid-LOAD.
    pulse_start();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(vecs[i].b, 1'b0);
    pulse_flush();
    repeat (2) @(negedge clk);
    chk("abort_in_drain", 64'(a_done), 64'd0);
    chk("abort_buffered_we", 64'(a_mem_we), 64'd1);
    pulse_start();
    chk("abort_we", 64'(a_mem_we), 64'd0);
    chk("abort_in_ready", 64'(a_in_ready), 64'd1);
    chk("abort_addr", 64'(a_mem_addr), 64'd0);
    chk("abort_count", 64'(a_count), 64'd0);
    send(vecs[3].b, 1'b0);
    @(negedge clk);
    chk("abort_new_we", 64'(a_mem_we), 64'd1);
    #1 rest = 1'b1;
    #1 chk_reset_a("arst");
    @(negedge clk);
    rest = 1'b0;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_nwrites", 64'(qa_addr.size()), 64'd0);
    chk_reset_a("post_arst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
